// File: rtl/tt_alu4_pkg.sv
// Shared definitions for the 4-bit ALU built-in self-test block.
//   state_t            : BIST sequencer states
//   OP_ADD..OP_PASS    : opcodes driven onto uio_out[2:0]
//   LAST_VECTOR        : final {opcode,A,B} index of a run (opcode 7 is never issued)
//   UIO_*_BIT          : bit positions on the uio bus
//   UIO_OE_VALUE       : fixed output-enable pattern (bit 3 is the start input)
package tt_alu4_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_PASS = 3'd6;

  localparam logic [10:0] LAST_VECTOR = 11'h6FF;

  localparam int UIO_START_BIT = 3;
  localparam int UIO_BUSY_BIT  = 4;
  localparam int UIO_DONE_BIT  = 5;
  localparam int UIO_PASS_BIT  = 6;
  localparam int UIO_FAIL_BIT  = 7;

  localparam logic [7:0] UIO_OE_VALUE = 8'b1111_0111;

endpackage

// File: rtl/alu4_golden.sv
// Combinational reference model of the external 4-bit ALU.
//   a, b     : 4-bit operands
//   opcode   : operation select (OP_ADD..OP_PASS)
//   expected : {carry, result[3:0]}
module alu4_golden
  import tt_alu4_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] opcode,
  output logic [4:0] expected
);

  always_comb begin
    expected = 5'd0;
    case (opcode)
      OP_ADD:  expected = {1'b0, a} + {1'b0, b};
      // Borrow lands in bit 4 when a < b.
      OP_SUB:  expected = {1'b0, a} - {1'b0, b};
      OP_AND:  expected = {1'b0, a & b};
      OP_OR:   expected = {1'b0, a | b};
      OP_XOR:  expected = {1'b0, a ^ b};
      OP_NOT:  expected = {1'b1, ~a};
      OP_PASS: expected = {1'b0, b};
      default: expected = 5'd0;
    endcase
  end

endmodule

// File: rtl/tt_um_sujith_alu4_bist.sv
// Exhaustive BIST sequencer for an external 4-bit ALU.
//   clk, rst_n : clock, synchronous active-low reset
//   ena        : 0 freezes all state and forces outputs to 0
//   ui_in      : ALU response, [7:4]=result, [0]=carry
//   uo_out     : stimulus {A,B}, or first failing {A,B} in DONE
//   uio_in     : [3]=start (rising-edge)
//   uio_out    : [2:0]=opcode, [4]=busy, [5]=done, [6]=pass, [7]=fail
//   uio_oe     : constant 8'b1111_0111
//
// state  | meaning
// IDLE   | waiting for start edge, outputs 0
// DRIVE  | present vector {opcode,A,B} for one cycle
// SETTLE | wait SETTLE_CYCLES for the ALU to respond
// CHECK  | compare response, advance index or finish
// DONE   | report pass/fail, wait for a new start edge
module tt_um_sujith_alu4_bist
  import tt_alu4_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

  state_t      state, state_nxt;
  logic [10:0] idx, idx_nxt;
  logic [3:0]  settle_cnt, settle_cnt_nxt;
  logic [10:0] cap_vec, cap_vec_nxt;
  logic        fail, fail_nxt;
  logic        start_q;
  logic        start_rise;
  logic        mismatch;
  logic [4:0]  expected;

  logic unused_bits;
  assign unused_bits = &{1'b0, ui_in[3:1], uio_in[7:4], uio_in[2:0]};

  assign uio_oe     = UIO_OE_VALUE;
  assign start_rise = uio_in[UIO_START_BIT] & ~start_q;

  alu4_golden u_golden (
    .a        (idx[7:4]),
    .b        (idx[3:0]),
    .opcode   (idx[10:8]),
    .expected (expected)
  );

  assign mismatch = ({ui_in[0], ui_in[7:4]} != expected);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= 11'd0;
      settle_cnt <= 4'd0;
      cap_vec    <= 11'd0;
      fail       <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      settle_cnt <= settle_cnt_nxt;
      cap_vec    <= cap_vec_nxt;
      fail       <= fail_nxt;
      if (ena) start_q <= uio_in[UIO_START_BIT];
    end
  end

  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    settle_cnt_nxt = settle_cnt;
    cap_vec_nxt    = cap_vec;
    fail_nxt       = fail;
    uo_out         = 8'd0;
    uio_out        = 8'd0;

    if (ena) begin
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            idx_nxt     = 11'd0;
            fail_nxt    = 1'b0;
            cap_vec_nxt = 11'd0;
            state_nxt   = DRIVE;
          end
        end
        DRIVE: begin
          settle_cnt_nxt = SETTLE_LOAD;
          state_nxt      = SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == 4'd0) state_nxt = CHECK;
          else                    settle_cnt_nxt = settle_cnt - 4'd1;
        end
        CHECK: begin
          // Only the first mismatch of a run is captured.
          if (mismatch && !fail) begin
            fail_nxt    = 1'b1;
            cap_vec_nxt = idx;
          end
          if (idx == LAST_VECTOR) begin
            state_nxt = DONE;
          end else begin
            idx_nxt   = idx + 11'd1;
            state_nxt = DRIVE;
          end
        end
        default: state_nxt = IDLE;
      endcase

      case (state)
        DRIVE, SETTLE, CHECK: begin
          uo_out                = idx[7:0];
          uio_out[2:0]          = idx[10:8];
          uio_out[UIO_BUSY_BIT] = 1'b1;
          uio_out[UIO_FAIL_BIT] = fail;
        end
        DONE: begin
          uio_out[UIO_DONE_BIT] = 1'b1;
          uio_out[UIO_PASS_BIT] = ~fail;
          uio_out[UIO_FAIL_BIT] = fail;
          if (fail) begin
            uo_out       = cap_vec[7:0];
            uio_out[2:0] = cap_vec[10:8];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_sujith_alu4_bist.sv
module tb_tt_um_sujith_alu4_bist;

  localparam int SETTLE = 2;
  localparam int RUN    = 1792 * (SETTLE + 2);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       fault_carry0 = 1'b0;

  int cycle = 0;
  int errors = 0;
  int checks = 0;
  int runs_seen = 0;

  typedef struct {
    int         t_start;
    int         latency;
    logic [7:0] uo;
    logic [7:0] uio;
  } exp_t;

  exp_t sb[$];
  exp_t e_mon;
  logic done_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  tt_um_sujith_alu4_bist #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // External ALU model looped back onto ui_in.
  function automatic logic [4:0] alu_ref(input logic [2:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
    logic [4:0] r;
    case (op)
      3'd0: r = {1'b0, a} + {1'b0, b};
      3'd1: r = {1'b0, a} - {1'b0, b};
      3'd2: r = {1'b0, a & b};
      3'd3: r = {1'b0, a | b};
      3'd4: r = {1'b0, a ^ b};
      3'd5: r = {1'b1, ~a};
      3'd6: r = {1'b0, b};
      default: r = 5'd0;
    endcase
    return r;
  endfunction

  logic [4:0] alu_r;
  always_comb begin
    alu_r = alu_ref(uio_out[2:0], uo_out[7:4], uo_out[3:0]);
    ui_in = {alu_r[3:0], 3'b000, alu_r[4] & ~fault_carry0};
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Monitor: each rising edge of done retires one scoreboard entry.
  always @(negedge clk) begin
    if (uio_out[5] && !done_prev) begin
      runs_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done at cycle %0d with no run expected", cycle);
      end else begin
        e_mon = sb.pop_front();
        checks++;
        if (cycle - e_mon.t_start != e_mon.latency) begin
          errors++;
          $display("FAIL run_latency: got %0d expected %0d", cycle - e_mon.t_start,
                   e_mon.latency);
        end
        check8("done_uo_out", uo_out, e_mon.uo);
        check8("done_uio_out", uio_out, e_mon.uio);
      end
    end
    done_prev = uio_out[5];
  end

  task automatic start_run(input bit expect_done, input int lat, input logic [7:0] uo,
                           input logic [7:0] uio, output int t);
    exp_t e;
    @(negedge clk);
    uio_in[3] = 1'b1;
    @(posedge clk);
    #1;
    t = cycle;
    if (expect_done) begin
      e.t_start = t;
      e.latency = lat;
      e.uo      = uo;
      e.uio     = uio;
      sb.push_back(e);
    end
    @(negedge clk);
    uio_in[3] = 1'b0;
  endtask

  task automatic wait_done(input int target, input string name);
    int n = 0;
    while (runs_seen < target && n < RUN + 300) begin
      @(negedge clk);
      n++;
    end
    if (runs_seen < target) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles", name, n);
    end
  endtask

  task automatic wait_cycle(input int target);
    while (cycle < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check8("reset_uo_out", uo_out, 8'h00);
    check8("reset_uio_out", uio_out, 8'h00);
    check8("reset_uio_oe", uio_oe, 8'hF7);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check8("idle_uo_out", uo_out, 8'h00);
    check8("idle_uio_out", uio_out, 8'h00);

    // Nominal run against a correct ALU.
    start_run(1, RUN, 8'h00, 8'h60, t);
    check8("first_drive_uio_out", uio_out, 8'h10);
    wait_done(1, "nominal");
    repeat (5) @(negedge clk);
    check8("done_hold_uio_out", uio_out, 8'h60);

    // Carry stuck at 0: first failure is ADD A=1 B=15; restart from DONE.
    fault_carry0 = 1'b1;
    start_run(1, RUN, 8'h1F, 8'hA0, t);
    wait_done(2, "carry0");
    repeat (5) @(negedge clk);
    check8("fail_hold_uo_out", uo_out, 8'h1F);
    fault_carry0 = 1'b0;

    // Start pulse 100 cycles into a run is ignored.
    start_run(1, RUN, 8'h00, 8'h60, t);
    wait_cycle(t + 100);
    @(negedge clk);
    uio_in[3] = 1'b1;
    @(negedge clk);
    uio_in[3] = 1'b0;
    wait_done(3, "start_busy");

    // Reset mid-run at index 0x3A5 (opcode 3, A=0xA, B=5).
    start_run(0, 0, 8'h00, 8'h00, t);
    wait_cycle(t + 4 * 'h3A5);
    @(negedge clk);
    check8("mid_run_uo_out", uo_out, 8'hA5);
    check8("mid_run_uio_out", uio_out, 8'h13);
    rst_n = 1'b0;
    @(negedge clk);
    check8("mid_reset_uo_out", uo_out, 8'h00);
    check8("mid_reset_uio_out", uio_out, 8'h00);
    check8("mid_reset_uio_oe", uio_oe, 8'hF7);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check8("post_reset_uo_out", uo_out, 8'h00);
    check8("post_reset_uio_out", uio_out, 8'h00);

    start_run(1, RUN, 8'h00, 8'h60, t);
    check8("restart_index_uo_out", uo_out, 8'h00);
    wait_done(4, "after_reset");

    // ena low for 50 cycles during SETTLE of vector 0.
    start_run(1, RUN + 50, 8'h00, 8'h60, t);
    @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    @(negedge clk);
    check8("ena_off_uo_out", uo_out, 8'h00);
    check8("ena_off_uio_out", uio_out, 8'h00);
    check8("ena_off_uio_oe", uio_oe, 8'hF7);
    repeat (49) @(posedge clk);
    @(negedge clk);
    ena = 1'b1;
    wait_done(5, "ena_pause");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_um_sujith_alu4_bist.md
TT_UM_SUJITH_ALU4_BIST -- requirements
Module: tt_um_sujith_alu4_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 2 (range 1-15): cycles the bench waits for the external ALU to respond before sampling.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-004 SHALL have port ena, input, 1: when 0, FSM, counters and flags freeze and uo_out/uio_out read 0.
REQ-005 SHALL have port ui_in, input, 8: ALU response; [7:4]=result, [0]=carry, [3:1] ignored.
REQ-006 SHALL have port uo_out, output, 8: stimulus {A[3:0],B[3:0]}, or the first failing {A,B} when in DONE with fail=1.
REQ-007 SHALL have port uio_in, input, 8: [3]=start, rising-edge sensitive; all other bits ignored.
REQ-008 SHALL have port uio_out, output, 8: [2:0]=opcode (or first failing opcode), [3]=0, [4]=busy, [5]=done, [6]=pass, [7]=fail.
REQ-009 SHALL have port uio_oe, output, 8: constant 8'b1111_0111.

Function
REQ-010 SHALL drive an external 4-bit ALU exhaustively: vector index {opcode[2:0],A[3:0],B[3:0]} runs 0x000 to 0x6FF; opcode is outermost and B innermost; opcode 7 is never issued.
REQ-011 SHALL use FSM states IDLE, DRIVE, SETTLE, CHECK, DONE.
REQ-012 IDLE: busy=0, done=0, and outputs are 0; a start rising edge (uio_in[3] registered, sampled 0 then 1) SHALL clear the index, pass, fail and capture registers and go to DRIVE.
REQ-013 DRIVE: stimulus registers present the current vector; one cycle; then go to SETTLE.
REQ-014 SETTLE: wait exactly SETTLE_CYCLES cycles; then go to CHECK.
REQ-015 CHECK: one cycle; compare ui_in[7:4] and ui_in[0] with the golden result; on the first mismatch, set fail and capture the vector. If the index is 0x6FF, go to DONE; otherwise increment the index and go to DRIVE.
REQ-016 Per-vector latency SHALL be SETTLE_CYCLES+2 cycles; a full run takes 1792*(SETTLE_CYCLES+2) cycles from the first DRIVE cycle.
REQ-017 Golden 5-bit result, {carry,result}, SHALL be:
- 0 ADD: A+B
- 1 SUB: A-B mod 32 (bit4=1 iff A<B)
- 2 AND: {0,A&B}
- 3 OR: {0,A|B}
- 4 XOR: {0,A^B}
- 5 NOT: {1,~A}
- 6 PASS: {0,B}
REQ-018 busy SHALL be 1 in DRIVE, SETTLE and CHECK.
REQ-019 DONE: done=1; pass = ~fail; state holds until start or reset.
REQ-020 In DONE with fail=1, uo_out and uio_out[2:0] SHALL show the captured first-failing vector; with fail=0 they SHALL show 0.
REQ-021 A start edge while busy SHALL be ignored; a start edge in DONE SHALL restart the run as from IDLE.
REQ-022 fail SHALL be sticky for the run; only the first mismatch is captured, and later mismatches do not overwrite it.
REQ-023 With ena=0, start edges SHALL not be detected, SETTLE counting SHALL pause, and the run SHALL resume from the same point when ena returns to 1.

Reset
REQ-024 With rst_n=0 at a clock edge, the block SHALL enter IDLE with index, settle counter, capture registers, start-edge register, pass and fail all 0; this applies at any point, including mid-run.
REQ-025 During and after reset, uo_out=0 and uio_out=0, and uio_oe SHALL be 8'b1111_0111 at all times.

Structure
REQ-026 Shared package tt_alu4_pkg SHALL hold:
- the state enum
- opcode constants OP_ADD..OP_PASS
- LAST_VECTOR=11'h6FF
- the uio bit-position constants
REQ-027 The golden model SHALL be a separate combinational sub-module, alu4_golden (inputs A, B, opcode; output 5-bit expected result), reusable by the testbench.

Verification
REQ-028 Reset: hold rst_n=0 for 3 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xF7.
REQ-029 Loopback to a correct ALU model, SETTLE_CYCLES=2, pulse start -> busy for 7168 cycles, then done=1, pass=1, fail=0, uio_out=0x60.
REQ-030 ALU model with carry stuck at 0 -> fail=1, pass=0, captured vector uo_out=0x1F, uio_out[2:0]=000 (A=1, B=15 ADD).
REQ-031 Start pulse at cycle 100 of a run -> run length unchanged, index not reset.
REQ-032 rst_n=0 for 1 cycle mid-run (index 0x3A5) -> IDLE, all outputs 0; a subsequent start -> full run from index 0.
REQ-033 ena=0 for 50 cycles mid-SETTLE -> done asserts exactly 50 cycles later than in the nominal run; result unchanged.
